note_step_sequencer: RTL and testbench

//  Autonomous step sequencer that drives the oscillator datapath without per-note SPI traffic.

---
 rtl/note_step_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_note_step_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_step_sequencer.sv
// Step sequencer: plays a small pattern of frequency words with programmable step and gate length.
// Optional build macro SEQ_LOOP_EN: wrap to step 0 after seq_last instead of returning to IDLE.
module note_step_sequencer #(
  parameter int STEPS    = 8,
  parameter int FREQ_W   = 24,
  parameter int TICK_DIV = 50000,
  parameter int AW       = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FREQ_W-1:0] wr_freq,
  input  logic              wr_rest,
  input  logic [AW-1:0]     seq_last,
  input  logic [7:0]        step_ticks,
  input  logic [7:0]        gate_ticks,
  output logic [FREQ_W-1:0] freq_out,
  output logic              gate_out,
  output logic [AW-1:0]     step_idx,
  output logic              step_strobe,
  output logic              running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE_ON  = 2'd1,
    ST_GATE_OFF = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     presc_r, presc_s;
  logic [7:0]        tick_cnt_r, tick_cnt_s;
  logic [FREQ_W-1:0] freq_out_r, freq_out_s;
  logic              gate_out_r, gate_out_s;
  logic [AW-1:0]     step_idx_r, step_idx_s;
  logic              step_strobe_r, step_strobe_s;
  logic              running_r;

  logic [FREQ_W-1:0] mem_freq_r [STEPS];
  logic              mem_rest_r [STEPS];

  logic              tick_s;
  logic [7:0]        eff_step_s;
  logic [8:0]        tick_next_s;
  logic              step_end_s;
  logic              gate_end_s;
  logic              enter_s;
  logic [AW-1:0]     enter_idx_s;

  assign tick_s      = (state_r != ST_IDLE) && (presc_r == PRESC_LAST);
  assign eff_step_s  = (step_ticks == 8'd0) ? 8'd1 : step_ticks;
  assign tick_next_s = {1'b0, tick_cnt_r} + 9'd1;
  assign step_end_s  = tick_s && (tick_next_s == {1'b0, eff_step_s});
  assign gate_end_s  = tick_s && (tick_next_s == {1'b0, gate_ticks}) && (gate_ticks < eff_step_s);

  // Pattern RAM: cleared on reset, written from the register bank in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_freq_r[i] <= {FREQ_W{1'b0}};
        mem_rest_r[i] <= 1'b0;
      end
    end else if (wr_en) begin
      mem_freq_r[wr_addr] <= wr_freq;
      mem_rest_r[wr_addr] <= wr_rest;
    end
  end

  // Next-state and output decode; step entry overrides the per-state defaults.
  always_comb begin
    state_s       = state_r;
    presc_s       = presc_r;
    tick_cnt_s    = tick_cnt_r;
    freq_out_s    = freq_out_r;
    gate_out_s    = gate_out_r;
    step_idx_s    = step_idx_r;
    step_strobe_s = 1'b0;
    enter_s       = 1'b0;
    enter_idx_s   = {AW{1'b0}};

    if (stop) begin
      state_s    = ST_IDLE;
      gate_out_s = 1'b0;
      presc_s    = {PW{1'b0}};
      tick_cnt_s = 8'd0;
    end else if (start) begin
      enter_s     = 1'b1;
      enter_idx_s = {AW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          gate_out_s = 1'b0;
        end
        ST_GATE_ON, ST_GATE_OFF: begin
          if (!tick_s) begin
            presc_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
          end else if (step_end_s) begin
            presc_s = {PW{1'b0}};
            if (step_idx_r != seq_last) begin
              enter_s     = 1'b1;
              enter_idx_s = step_idx_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
`ifdef SEQ_LOOP_EN
              enter_s     = 1'b1;
              enter_idx_s = {AW{1'b0}};
`else
              state_s    = ST_IDLE;
              gate_out_s = 1'b0;
              tick_cnt_s = 8'd0;
`endif
            end
          end else begin
            presc_s    = {PW{1'b0}};
            tick_cnt_s = tick_next_s[7:0];
            if ((state_r == ST_GATE_ON) && gate_end_s) begin
              gate_out_s = 1'b0;
              state_s    = ST_GATE_OFF;
            end else begin
              gate_out_s = gate_out_r;
            end
          end
        end
        default: begin
          state_s    = ST_IDLE;
          gate_out_s = 1'b0;
          presc_s    = {PW{1'b0}};
          tick_cnt_s = 8'd0;
        end
      endcase
    end

    // Entry reads the RAM's current contents, so a same-cycle write is heard next visit.
    if (enter_s) begin
      step_idx_s    = enter_idx_s;
      freq_out_s    = mem_freq_r[enter_idx_s];
      step_strobe_s = 1'b1;
      tick_cnt_s    = 8'd0;
      presc_s       = {PW{1'b0}};
      gate_out_s    = !mem_rest_r[enter_idx_s] && (gate_ticks != 8'd0);
      state_s       = gate_out_s ? ST_GATE_ON : ST_GATE_OFF;
    end else begin
      step_strobe_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      presc_r       <= {PW{1'b0}};
      tick_cnt_r    <= 8'd0;
      freq_out_r    <= {FREQ_W{1'b0}};
      gate_out_r    <= 1'b0;
      step_idx_r    <= {AW{1'b0}};
      step_strobe_r <= 1'b0;
      running_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      presc_r       <= presc_s;
      tick_cnt_r    <= tick_cnt_s;
      freq_out_r    <= freq_out_s;
      gate_out_r    <= gate_out_s;
      step_idx_r    <= step_idx_s;
      step_strobe_r <= step_strobe_s;
      running_r     <= (state_s != ST_IDLE);
    end
  end

  assign freq_out    = freq_out_r;
  assign gate_out    = gate_out_r;
  assign step_idx    = step_idx_r;
  assign step_strobe = step_strobe_r;
  assign running     = running_r;

endmodule

// File: tb/tb_note_step_sequencer.sv
// Scoreboard bench for note_step_sequencer: a schedule model predicts every step entry and gate window.
module tb_note_step_sequencer;

  localparam int STEPS = 8;
  localparam int FW    = 24;
  localparam int TD    = 4;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, wr_en = 1'b0, wr_rest = 1'b0;
  logic [AW-1:0] wr_addr = '0, seq_last = '0;
  logic [FW-1:0] wr_freq = '0;
  logic [7:0]    step_ticks = 8'd0, gate_ticks = 8'd0;
  logic [FW-1:0] freq_out;
  logic          gate_out, step_strobe, running;
  logic [AW-1:0] step_idx;

  note_step_sequencer #(.STEPS(STEPS), .FREQ_W(FW), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_rest(wr_rest),
    .seq_last(seq_last), .step_ticks(step_ticks), .gate_ticks(gate_ticks),
    .freq_out(freq_out), .gate_out(gate_out), .step_idx(step_idx),
    .step_strobe(step_strobe), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          idx;
    logic [FW-1:0] freq;
    int          gate_clks;
    int          len;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   mon_on = 1'b0;
  int   tot = 0, bad = 0;

  // reference pattern
  logic [FW-1:0] m_freq [STEPS];
  bit            m_rest [STEPS];

  int r_s, r_L, r_n, r_last_idx;
  logic [FW-1:0] r_last_freq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // monitor: pops an expectation on each strobe, then checks the gate window of that step
  always @(negedge clk) begin
    if (!mon_on) begin
      have_cur = 1'b0;
    end else begin
      if (step_strobe !== 1'b0) begin
        if (q.size() == 0) begin
          tot++;
          bad++;
          $display("FAIL unexpected_strobe at cycle %0d: got strobe=%b idx=%0d expected no strobe", cyc, step_strobe, step_idx);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk("strobe_cycle", cyc, cur.at);
          chk("step_idx", 32'(step_idx), cur.idx);
          chk("freq_out", 32'(freq_out), 32'(cur.freq));
        end
      end
      if (have_cur) begin
        int off;
        off = cyc - cur.at;
        if (off >= cur.len) have_cur = 1'b0;
        else begin
          chk("gate_out", 32'(gate_out), (off < cur.gate_clks) ? 1 : 0);
          chk("running", 32'(running), 1);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [FW-1:0] f, input bit r);
    wr_en = 1'b1; wr_addr = AW'(a); wr_freq = f; wr_rest = r;
    m_freq[a] = f; m_rest[a] = r;
    for (int i = 0; i < q.size(); i++) if (q[i].idx == a) q[i].freq = f;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // start playback and schedule n step entries from the pattern rules
  task automatic begin_run(input int sl, input int st, input int gt, input int n);
    int eff, idx;
    exp_t e;
    eff = (st == 0) ? 1 : st;
    seq_last = AW'(sl); step_ticks = 8'(st); gate_ticks = 8'(gt);
    start = 1'b1;
    r_s = cyc; r_L = eff * TD; r_n = n;
    idx = 0;
    for (int k = 0; k < n; k++) begin
      e.at = r_s + 1 + k * r_L;
      e.idx = idx;
      e.freq = m_freq[idx];
      e.len = r_L;
      if (m_rest[idx] || gt == 0) e.gate_clks = 0;
      else if (gt >= eff) e.gate_clks = r_L;
      else e.gate_clks = gt * TD;
      q.push_back(e);
      r_last_idx = idx;
      r_last_freq = m_freq[idx];
      idx = (idx == sl) ? 0 : (idx + 1) % STEPS;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_run(input bit do_stop);
    if (do_stop) begin
      wait_cyc(r_s + r_n * r_L);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end else begin
      wait_cyc(r_s + r_n * r_L + 1);
    end
    chk("idle_running", 32'(running), 0);
    chk("idle_gate", 32'(gate_out), 0);
    chk("idle_strobe", 32'(step_strobe), 0);
    chk("idle_step_idx", 32'(step_idx), r_last_idx);
    chk("idle_freq", 32'(freq_out), 32'(r_last_freq));
    chk("queue_empty", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic full_run(input int sl, input int st, input int gt);
`ifdef SEQ_LOOP_EN
    begin_run(sl, st, gt, sl + 3);
    end_run(1'b1);
`else
    begin_run(sl, st, gt, sl + 1);
    end_run(1'b0);
`endif
  endtask

  initial begin
    for (int i = 0; i < STEPS; i++) begin m_freq[i] = '0; m_rest[i] = 1'b0; end
    repeat (2) @(negedge clk);
    chk("rst_freq", 32'(freq_out), 0);
    chk("rst_gate", 32'(gate_out), 0);
    chk("rst_idx", 32'(step_idx), 0);
    chk("rst_strobe", 32'(step_strobe), 0);
    chk("rst_running", 32'(running), 0);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    // basic three-step pattern
    wr(0, 24'h001000, 1'b0);
    wr(1, 24'h002000, 1'b0);
    wr(2, 24'h003000, 1'b0);
    full_run(2, 3, 2);
    // rest entry: strobe and freq still update, gate stays low
    wr(1, 24'h002000, 1'b1);
    full_run(2, 3, 2);
    wr(1, 24'h002000, 1'b0);
    // legato: gate longer than the step
    full_run(2, 3, 5);
    // stop on the step-end tick of step 1
    begin_run(2, 3, 2, 2);
    end_run(1'b1);
    // restart during step 2
    begin_run(2, 3, 2, 3);
    wait_cyc(r_s + 1 + 2 * r_L + 5);
    begin_run(2, 3, 2, 3);
    end_run(1'b0);
    // write the playing entry during step 1, heard on its next visit
    begin_run(2, 3, 2, 3);
    wait_cyc(r_s + 1 + r_L + 3);
    chk("hold_freq_before_wr", 32'(freq_out), 32'h002000);
    wr(1, 24'h00ABCD, 1'b0);
    chk("hold_freq_after_wr", 32'(freq_out), 32'h002000);
    end_run(1'b0);
    full_run(2, 3, 2);

    // randomized pattern, lengths and early stops
    for (int r = 0; r < 20; r++) begin
      int sl, st, gt, n;
      for (int i = 0; i < STEPS; i++)
        if ($urandom_range(0, 1) == 1) wr(i, FW'($urandom), ($urandom_range(0, 3) == 0));
      sl = $urandom_range(0, STEPS - 1);
      st = $urandom_range(0, 4);
      gt = $urandom_range(0, 5);
`ifdef SEQ_LOOP_EN
      n = $urandom_range(1, 2 * sl + 3);
      begin_run(sl, st, gt, n);
      end_run(1'b1);
`else
      n = $urandom_range(1, sl + 1);
      begin_run(sl, st, gt, n);
      end_run(n < sl + 1);
`endif
    end

    // reset mid-step clears outputs and pattern
    begin_run(2, 3, 2, 3);
    wait_cyc(r_s + 1 + r_L + 2);
    mon_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_freq", 32'(freq_out), 0);
    chk("midrst_gate", 32'(gate_out), 0);
    chk("midrst_idx", 32'(step_idx), 0);
    chk("midrst_strobe", 32'(step_strobe), 0);
    chk("midrst_running", 32'(running), 0);
    q.delete();
    for (int i = 0; i < STEPS; i++) begin m_freq[i] = '0; m_rest[i] = 1'b0; end
    @(negedge clk);
    mon_on = 1'b1;
    full_run(3, 1, 1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
